// File: rtl/light_phase_timer_if.sv
// Control/status bundle between the intersection controller and the light phase timer.
// The controller drives the master side; the timer is the slave.
interface light_phase_timer_if #(
  parameter int unsigned pCH_NUM    = 2,
  parameter int unsigned pCNT_WIDTH = 5
);
  logic                          tick;
  logic                          cfg_we;
  logic [1:0]                    cfg_sel;
  logic [pCNT_WIDTH-1:0]         cfg_data;
  logic [pCH_NUM-1:0]            auto_seq;
  logic [3*pCH_NUM-1:0]          init;
  logic [pCH_NUM-1:0]            hold;
  logic [pCH_NUM-1:0]            extend;
  logic [pCH_NUM*pCNT_WIDTH-1:0] cnt_out;
  logic [2*pCH_NUM-1:0]          phase;
  logic [pCH_NUM-1:0]            busy;
  logic [pCH_NUM-1:0]            last;

  modport master (
    output tick, cfg_we, cfg_sel, cfg_data, auto_seq, init, hold, extend,
    input  cnt_out, phase, busy, last
  );

  modport slave (
    input  tick, cfg_we, cfg_sel, cfg_data, auto_seq, init, hold, extend,
    output cnt_out, phase, busy, last
  );
endinterface

// File: rtl/light_phase_timer.sv
// Multi-channel green/yellow/red phase countdown with shared programmable durations,
// optional auto-sequencing, per-channel hold and green extension.
module light_phase_timer #(
  parameter int unsigned pCH_NUM     = 2,
  parameter int unsigned pCNT_WIDTH  = 5,
  parameter int unsigned pGREEN_DEF  = 14,
  parameter int unsigned pYELLOW_DEF = 2,
  parameter int unsigned pRED_DEF    = 17,
  parameter int unsigned pEXT_VAL    = 5
) (
  input logic               clk,
  input logic               rst,
  light_phase_timer_if.slave bus
);

  localparam int unsigned W = pCNT_WIDTH;
  localparam logic [W:0]  ExtVal = (W+1)'(pEXT_VAL);
  localparam logic [W:0]  CntMax = {1'b0, {W{1'b1}}};

  typedef enum logic [1:0] {
    PhOff    = 2'b00,
    PhGreen  = 2'b01,
    PhYellow = 2'b10,
    PhRed    = 2'b11
  } phase_e;

  // Duration registers: index 0 green, 1 yellow, 2 red.
  logic [W-1:0]       dur_q   [3];
  logic [W-1:0]       dur_d   [3];
  logic [W-1:0]       cnt_q   [pCH_NUM];
  logic [W-1:0]       cnt_d   [pCH_NUM];
  phase_e             phase_q [pCH_NUM];
  phase_e             phase_d [pCH_NUM];
  logic [pCH_NUM-1:0] busy_q, busy_d;
  logic [pCH_NUM-1:0] last_q, last_d;

  function automatic logic [W-1:0] dur_of(phase_e ph, logic [W-1:0] g, logic [W-1:0] y,
                                          logic [W-1:0] r);
    unique case (ph)
      PhGreen:  dur_of = g;
      PhYellow: dur_of = y;
      default:  dur_of = r;
    endcase
  endfunction

  always_comb begin
    logic [2:0]   init_c;
    logic         tick_eff;
    logic         ext_eff;
    logic [W:0]   sum;
    logic [W-1:0] sat;
    logic [W-1:0] nxt;
    phase_e       adv;

    for (int d = 0; d < 3; d++) dur_d[d] = dur_q[d];
    busy_d = busy_q;
    last_d = '0;

    for (int i = 0; i < pCH_NUM; i++) begin
      cnt_d[i]   = cnt_q[i];
      phase_d[i] = phase_q[i];
      init_c     = bus.init[3*i +: 3];
      tick_eff   = bus.tick & busy_q[i] & ~bus.hold[i];
      ext_eff    = bus.extend[i] & busy_q[i] & (phase_q[i] == PhGreen);
      sum        = {1'b0, cnt_q[i]} + (ext_eff ? ExtVal : '0);
      sat        = (sum > CntMax) ? CntMax[W-1:0] : sum[W-1:0];
      nxt        = sat - W'(tick_eff);
      unique case (phase_q[i])
        PhGreen:  adv = PhYellow;
        PhYellow: adv = PhRed;
        default:  adv = PhGreen;
      endcase

      // Only a clean one-hot init loads; multi-hot falls through to normal counting.
      case (init_c)
        3'b001, 3'b010, 3'b100: begin
          phase_d[i] = (init_c == 3'b001) ? PhGreen : (init_c == 3'b010) ? PhYellow : PhRed;
          cnt_d[i]   = dur_of(phase_d[i], dur_q[0], dur_q[1], dur_q[2]);
          busy_d[i]  = 1'b1;
        end
        default: begin
          if (busy_q[i]) begin
            if (nxt == '0) begin
              last_d[i] = 1'b1;
              if (bus.auto_seq[i]) begin
                phase_d[i] = adv;
                cnt_d[i]   = dur_of(adv, dur_q[0], dur_q[1], dur_q[2]);
              end else begin
                cnt_d[i]  = '0;
                busy_d[i] = 1'b0;
              end
            end else begin
              cnt_d[i] = nxt;
            end
          end
        end
      endcase
    end

    // Loads above read dur_q, so a same-cycle write is only seen by later loads.
    if (bus.cfg_we) begin
      case (bus.cfg_sel)
        2'b00:   dur_d[0] = (bus.cfg_data == '0) ? W'(1) : bus.cfg_data;
        2'b01:   dur_d[1] = (bus.cfg_data == '0) ? W'(1) : bus.cfg_data;
        2'b10:   dur_d[2] = (bus.cfg_data == '0) ? W'(1) : bus.cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_q[0] <= W'(pGREEN_DEF);
      dur_q[1] <= W'(pYELLOW_DEF);
      dur_q[2] <= W'(pRED_DEF);
      for (int i = 0; i < pCH_NUM; i++) begin
        cnt_q[i]   <= '0;
        phase_q[i] <= PhOff;
      end
      busy_q <= '0;
      last_q <= '0;
    end else begin
      for (int d = 0; d < 3; d++) dur_q[d] <= dur_d[d];
      for (int i = 0; i < pCH_NUM; i++) begin
        cnt_q[i]   <= cnt_d[i];
        phase_q[i] <= phase_d[i];
      end
      busy_q <= busy_d;
      last_q <= last_d;
    end
  end

  for (genvar g = 0; g < pCH_NUM; g++) begin : gen_out
    assign bus.cnt_out[g*W +: W] = cnt_q[g];
    assign bus.phase[2*g +: 2]   = phase_q[g];
  end
  assign bus.busy = busy_q;
  assign bus.last = last_q;

endmodule

// File: tb/tb_light_phase_timer.sv
// Self-checking bench for light_phase_timer: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_light_phase_timer;
  localparam int CH  = 2;
  localparam int W   = 5;
  localparam int EXT = 5;
  localparam int MAX = 31;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  light_phase_timer_if #(.pCH_NUM(CH), .pCNT_WIDTH(W)) bus ();

  light_phase_timer #(
    .pCH_NUM(CH), .pCNT_WIDTH(W), .pGREEN_DEF(14), .pYELLOW_DEF(2), .pRED_DEF(17),
    .pEXT_VAL(EXT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit busy_drop;

  // Behavioural model: phase 0 off, 1 green, 2 yellow, 3 red.
  int m_cnt [CH];
  int m_ph  [CH];
  bit m_busy[CH];
  bit m_last[CH];
  int m_dur [3];

  typedef struct {
    logic [5:0] init;
    logic [1:0] hold;
    logic [1:0] ext;
    logic       tick;
    int         cnt0;
    int         cnt1;
    logic [3:0] ph;
    logic [1:0] busy;
    logic [1:0] last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_busy[i] = 0; m_last[i] = 0;
    end
    m_dur[0] = 14; m_dur[1] = 2; m_dur[2] = 17;
  endfunction

  function automatic void model_step();
    int ini;
    int n;
    bit t;
    bit e;
    for (int i = 0; i < CH; i++) begin
      ini = int'(bus.init[3*i +: 3]);
      m_last[i] = 0;
      if (ini == 1 || ini == 2 || ini == 4) begin
        m_ph[i]   = (ini == 1) ? 1 : (ini == 2) ? 2 : 3;
        m_cnt[i]  = m_dur[m_ph[i]-1];
        m_busy[i] = 1;
      end else if (m_busy[i]) begin
        t = bus.tick && !bus.hold[i];
        e = bus.extend[i] && (m_ph[i] == 1);
        n = m_cnt[i] + (e ? EXT : 0);
        if (n > MAX) n = MAX;
        n = n - (t ? 1 : 0);
        if (n == 0) begin
          m_last[i] = 1;
          if (bus.auto_seq[i]) begin
            m_ph[i]  = (m_ph[i] == 3) ? 1 : m_ph[i] + 1;
            m_cnt[i] = m_dur[m_ph[i]-1];
          end else begin
            m_busy[i] = 0;
            m_cnt[i]  = 0;
          end
        end else begin
          m_cnt[i] = n;
        end
      end
    end
    if (bus.cfg_we && bus.cfg_sel != 2'b11)
      m_dur[bus.cfg_sel] = (bus.cfg_data == 0) ? 1 : int'(bus.cfg_data);
  endfunction

  task automatic check_model();
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("model_cnt%0d", i), 32'(bus.cnt_out[i*W +: W]), m_cnt[i]);
      chk($sformatf("model_phase%0d", i), 32'(bus.phase[2*i +: 2]), m_ph[i]);
      chk($sformatf("model_busy%0d", i), 32'(bus.busy[i]), 32'(m_busy[i]));
      chk($sformatf("model_last%0d", i), 32'(bus.last[i]), 32'(m_last[i]));
    end
  endtask

  task automatic cycle();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_idle();
    bus.tick = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_data = 0;
    bus.init = 0; bus.hold = 0; bus.extend = 0;
  endtask

  task automatic do_reset();
    set_idle();
    bus.auto_seq = 0;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic run_until_last(input int ch, output int n);
    n = 0;
    do begin
      cycle();
      n++;
      if (!bus.busy[ch]) busy_drop = 1;
    end while (!bus.last[ch] && n < 100);
  endtask

  vec_t vec[11];
  int   n;

  initial begin
    rst = 1;
    set_idle();
    bus.auto_seq = 0;
    model_reset();
    #2;
    chk("reset_cnt", 32'(bus.cnt_out), 0);
    chk("reset_phase", 32'(bus.phase), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    do_reset();

    // Table: ch0/ch1 load, hold, extend, multi-hot, expiry and idle behaviour.
    vec[0]  = '{6'b001_100, 2'b00, 2'b00, 1'b1, 17, 14, 4'b0111, 2'b11, 2'b00};
    vec[1]  = '{6'b000_000, 2'b00, 2'b00, 1'b1, 16, 13, 4'b0111, 2'b11, 2'b00};
    vec[2]  = '{6'b000_000, 2'b01, 2'b00, 1'b1, 16, 12, 4'b0111, 2'b11, 2'b00};
    vec[3]  = '{6'b000_000, 2'b00, 2'b11, 1'b1, 15, 16, 4'b0111, 2'b11, 2'b00};
    vec[4]  = '{6'b000_000, 2'b10, 2'b10, 1'b1, 14, 21, 4'b0111, 2'b11, 2'b00};
    vec[5]  = '{6'b110_000, 2'b10, 2'b00, 1'b1, 13, 21, 4'b0111, 2'b11, 2'b00};
    vec[6]  = '{6'b000_010, 2'b00, 2'b00, 1'b1,  2, 20, 4'b0110, 2'b11, 2'b00};
    vec[7]  = '{6'b000_000, 2'b00, 2'b00, 1'b1,  1, 19, 4'b0110, 2'b11, 2'b00};
    vec[8]  = '{6'b000_000, 2'b00, 2'b00, 1'b1,  0, 18, 4'b0110, 2'b10, 2'b01};
    vec[9]  = '{6'b000_000, 2'b00, 2'b00, 1'b1,  0, 17, 4'b0110, 2'b10, 2'b00};
    vec[10] = '{6'b000_000, 2'b00, 2'b01, 1'b0,  0, 17, 4'b0110, 2'b10, 2'b00};
    for (int v = 0; v < 11; v++) begin
      bus.init = vec[v].init; bus.hold = vec[v].hold;
      bus.extend = vec[v].ext; bus.tick = vec[v].tick;
      cycle();
      chk($sformatf("vec%0d_cnt0", v), 32'(bus.cnt_out[W-1:0]), vec[v].cnt0);
      chk($sformatf("vec%0d_cnt1", v), 32'(bus.cnt_out[2*W-1:W]), vec[v].cnt1);
      chk($sformatf("vec%0d_phase", v), 32'(bus.phase), 32'(vec[v].ph));
      chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(vec[v].busy));
      chk($sformatf("vec%0d_last", v), 32'(bus.last), 32'(vec[v].last));
    end

    // Auto-sequence on ch1: green 14, yellow 2, red 17, back to green.
    do_reset();
    bus.auto_seq = 2'b10;
    bus.init = 6'b001_000; bus.tick = 1;
    cycle();
    bus.init = 0;
    busy_drop = 0;
    run_until_last(1, n); chk("auto_green_ticks", n, 14);
    run_until_last(1, n); chk("auto_yellow_ticks", n, 2);
    run_until_last(1, n); chk("auto_red_ticks", n, 17);
    chk("auto_wrap_phase", 32'(bus.phase[3:2]), 1);
    chk("auto_wrap_cnt", 32'(bus.cnt_out[2*W-1:W]), 14);
    chk("auto_busy_steady", 32'(busy_drop), 0);

    // Duration writes: same-cycle load sees old value; zero stored as one.
    do_reset();
    bus.init = 6'b000_010; bus.cfg_we = 1; bus.cfg_sel = 2'b01; bus.cfg_data = 5'd4;
    cycle();
    chk("cfg_same_cycle_load", 32'(bus.cnt_out[W-1:0]), 2);
    bus.cfg_we = 0;
    cycle();
    chk("cfg_new_yellow", 32'(bus.cnt_out[W-1:0]), 4);
    bus.init = 0; bus.cfg_we = 1; bus.cfg_data = 5'd0;
    cycle();
    bus.cfg_we = 0; bus.init = 6'b000_010;
    cycle();
    chk("cfg_zero_as_one", 32'(bus.cnt_out[W-1:0]), 1);
    bus.cfg_we = 1; bus.cfg_sel = 2'b11; bus.cfg_data = 5'd9; bus.init = 0;
    cycle();
    bus.cfg_we = 0; bus.init = 6'b000_001;
    cycle();
    chk("cfg_sel3_noop", 32'(bus.cnt_out[W-1:0]), 14);

    // Extension: +5 with tick at cnt 3, saturation at max, ignored outside green.
    do_reset();
    bus.init = 6'b000_001;
    cycle();
    bus.init = 0; bus.tick = 1;
    repeat (11) cycle();
    chk("ext_pre", 32'(bus.cnt_out[W-1:0]), 3);
    bus.extend = 2'b01;
    cycle();
    chk("ext_with_tick", 32'(bus.cnt_out[W-1:0]), 7);
    bus.tick = 0;
    repeat (4) cycle();
    chk("ext_to_27", 32'(bus.cnt_out[W-1:0]), 27);
    cycle();
    chk("ext_saturate", 32'(bus.cnt_out[W-1:0]), 31);
    bus.tick = 1;
    cycle();
    chk("ext_sat_tick", 32'(bus.cnt_out[W-1:0]), 30);
    bus.init = 6'b000_100; bus.tick = 0;
    cycle();
    bus.init = 0;
    cycle();
    chk("ext_red_ignored", 32'(bus.cnt_out[W-1:0]), 17);

    // Hold freezes; load during hold reloads; multi-hot init ignored.
    bus.extend = 0; bus.tick = 1;
    repeat (8) cycle();
    chk("hold_pre", 32'(bus.cnt_out[W-1:0]), 9);
    bus.hold = 2'b01;
    repeat (10) cycle();
    chk("hold_frozen", 32'(bus.cnt_out[W-1:0]), 9);
    bus.init = 6'b000_001;
    cycle();
    chk("hold_reload", 32'(bus.cnt_out[W-1:0]), 14);
    bus.init = 6'b001_110;
    cycle();
    chk("hold_multihot", 32'(bus.cnt_out[W-1:0]), 14);
    chk("hold_ch1_load", 32'(bus.cnt_out[2*W-1:W]), 14);

    // Async reset mid-count, then durations back to defaults.
    bus.init = 0; bus.hold = 0;
    bus.cfg_we = 1; bus.cfg_sel = 2'b00; bus.cfg_data = 5'd3;
    cycle();
    bus.cfg_sel = 2'b10; bus.cfg_data = 5'd9;
    cycle();
    bus.cfg_we = 0;
    cycle();
    #2 rst = 1;
    #1;
    chk("arst_cnt", 32'(bus.cnt_out), 0);
    chk("arst_phase", 32'(bus.phase), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_last", 32'(bus.last), 0);
    model_reset();
    set_idle();
    @(posedge clk);
    #1 rst = 0;
    bus.init = 6'b010_001;
    cycle();
    chk("def_green", 32'(bus.cnt_out[W-1:0]), 14);
    chk("def_yellow", 32'(bus.cnt_out[2*W-1:W]), 2);
    bus.init = 6'b000_100;
    cycle();
    chk("def_red", 32'(bus.cnt_out[W-1:0]), 17);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bus.tick   = ($urandom_range(3) != 0);
      bus.cfg_we = ($urandom_range(15) == 0);
      bus.cfg_sel = 2'($urandom_range(3));
      bus.cfg_data = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      if ($urandom_range(31) == 0) bus.auto_seq = 2'($urandom_range(3));
      for (int i = 0; i < CH; i++) begin
        bus.init[3*i +: 3] = ($urandom_range(11) == 0) ? 3'($urandom_range(7)) : 3'b000;
        bus.hold[i]   = ($urandom_range(4) == 0);
        bus.extend[i] = ($urandom_range(5) == 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
